// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, stall levels, load-op codes and the EX->MEM
// bus layout for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int StallBus     = 6;
    localparam int EX_TO_MEM_WD = 79;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_RF_WD = 38;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Load width/extension selector carried in ex_to_mem_bus[78:76].
    // Codes above MemLHU are not issued by EX and decode as a word load.
    localparam logic [2:0] MemLW  = 3'b000;
    localparam logic [2:0] MemLB  = 3'b001;
    localparam logic [2:0] MemLBU = 3'b010;
    localparam logic [2:0] MemLH  = 3'b011;
    localparam logic [2:0] MemLHU = 3'b100;

    // Field order matches the flat ex_to_mem_bus, MSB first.
    typedef struct packed {
        logic [2:0]  mem_op;       // 78:76
        logic [31:0] pc;           // 75:44
        logic        data_ram_en;  // 43
        logic [3:0]  data_ram_wen; // 42:39
        logic        sel_rf_res;   // 38
        logic        rf_we;        // 37
        logic [4:0]  rf_waddr;     // 36:32
        logic [31:0] ex_result;    // 31:0
    } ex_mem_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: extracts the addressed byte/halfword (or the whole word) from
// SRAM read data and sign- or zero-extends it to 32 bits.
//   mem_op    in  3   load type (MemLW/LB/LBU/LH/LHU; others act as LW)
//   addr      in  2   low address bits of the access
//   rdata     in  32  word read from the data SRAM
//   load_data out 32  extended load result
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr)
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase

        // Halfword picks by addr[1] only; an odd address is not trapped here.
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        case (mem_op)
            MemLB:   load_data = {{24{byte_v[7]}}, byte_v};
            MemLBU:  load_data = {24'd0, byte_v};
            MemLH:   load_data = {{16{half_v[15]}}, half_v};
            MemLHU:  load_data = {16'd0, half_v};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB.
// Registers the EX->MEM bus under the stall vector, aligns SRAM load data,
// picks load data or ALU result for write-back, and keeps the SRAM word of
// a load that is frozen in MEM so its write-back value stays stable.
//   clk, rst          clock, synchronous active-high reset
//   stall        in   6   bit 3 holds this stage's register, bit 4 holds WB
//   ex_to_mem_bus in  79  instruction bundle from EX
//   data_sram_rdata in 32 SRAM read data answering last cycle's EX request
//   mem_to_wb_bus out 70  {pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_rf_bus out 38  {rf_we, rf_waddr, rf_wdata} forwarding to ID
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

    ex_mem_bus_t bus_r;
    logic [31:0] rdata_buf;
    logic        buf_valid;

    logic        bubble;
    logic        advance;
    logic        is_load;
    logic [31:0] rd;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    // Only bits 3 and 4 matter to this stage.
    logic unused_stall;
    assign unused_stall = &{1'b0, stall[5], stall[2:0]};

    assign bubble  = (stall[3] == Stop) && (stall[4] == NoStop);
    assign advance = (stall[3] == NoStop);
    assign is_load = bus_r.data_ram_en && (bus_r.data_ram_wen == 4'd0);

    always_ff @(posedge clk) begin
        if (rst)
            bus_r <= '0;
        else if (bubble)
            bus_r <= '0;
        else if (advance)
            bus_r <= ex_to_mem_bus;
    end

    // The SRAM answers once; if the load sits in MEM longer, keep that
    // first-cycle word. Any register change (new value or bubble) drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_buf <= 32'd0;
            buf_valid <= 1'b0;
        end else if (bubble || advance) begin
            buf_valid <= 1'b0;
        end else if (is_load && (stall[4] == Stop) && !buf_valid) begin
            rdata_buf <= data_sram_rdata;
            buf_valid <= 1'b1;
        end
    end

    assign rd = buf_valid ? rdata_buf : data_sram_rdata;

    load_align u_load_align (
        .mem_op    (bus_r.mem_op),
        .addr      (bus_r.ex_result[1:0]),
        .rdata     (rd),
        .load_data (load_data)
    );

    assign rf_wdata      = bus_r.sel_rf_res ? load_data : bus_r.ex_result;
    assign mem_to_wb_bus = {bus_r.pc, bus_r.rf_we, bus_r.rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {bus_r.rf_we, bus_r.rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [78:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_rf_bus;

    int compared   = 0;
    int mismatched = 0;

    // Reference view: the instruction currently occupying MEM, and whether
    // it has been held long enough to keep the word it first saw.
    logic [78:0] m_instr;
    logic        m_frozen;
    logic [31:0] m_seen;

    localparam logic [5:0] S_RUN    = 6'b000000;
    localparam logic [5:0] S_HOLD   = 6'b011111;
    localparam logic [5:0] S_BUBBLE = 6'b001111;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_rf_bus   (mem_to_rf_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [78:0] mk(input logic [2:0] op, input logic [31:0] pc,
                                       input logic en, input logic [3:0] wen,
                                       input logic sel, input logic we,
                                       input logic [4:0] waddr, input logic [31:0] res);
        return {op, pc, en, wen, sel, we, waddr, res};
    endfunction

    function automatic logic is_load(input logic [78:0] b);
        return b[43] && (b[42:39] == 4'd0);
    endfunction

    // Load result from the ISA rules, with shifts and masks.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        int unsigned v;
        case (op)
            3'd1, 3'd2: begin
                v = (w >> (8 * a)) & 32'hFF;
                if (op == 3'd1 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            3'd3, 3'd4: begin
                v = (w >> (a >= 2 ? 16 : 0)) & 32'hFFFF;
                if (op == 3'd3 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [69:0] exp_wb();
        logic [31:0] w;
        logic [31:0] wd;
        w  = m_frozen ? m_seen : data_sram_rdata;
        wd = m_instr[38] ? ref_load(m_instr[78:76], m_instr[1:0], w) : m_instr[31:0];
        return {m_instr[75:44], m_instr[37], m_instr[36:32], wd};
    endfunction

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [69:0] e;
        e = exp_wb();
        chk({tag, ".wb"}, mem_to_wb_bus, e);
        chk({tag, ".rf"}, {32'd0, mem_to_rf_bus}, {32'd0, e[37:0]});
        chk({tag, ".bufv"}, {69'd0, dut.buf_valid}, {69'd0, m_frozen});
    endtask

    // One clock: advance the reference on the edge, return at the negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_instr = '0; m_frozen = 1'b0; m_seen = '0;
        end else if (stall[3] && !stall[4]) begin
            m_instr = '0; m_frozen = 1'b0;
        end else if (!stall[3]) begin
            m_instr = ex_to_mem_bus; m_frozen = 1'b0;
        end else if (is_load(m_instr) && !m_frozen) begin
            // Instruction stays in MEM: it keeps the word it first saw.
            m_frozen = 1'b1; m_seen = data_sram_rdata;
        end
        @(negedge clk);
    endtask

    initial begin
        m_instr = '0; m_frozen = 1'b0; m_seen = '0;
        rst = 1'b1; stall = S_RUN; ex_to_mem_bus = '0; data_sram_rdata = 32'h5555_AAAA;
        tick(); tick();
        #1;
        chk("reset.wb", mem_to_wb_bus, 70'd0);
        chk("reset.rf", {32'd0, mem_to_rf_bus}, 70'd0);
        chk("reset.bufv", {69'd0, dut.buf_valid}, 70'd0);
        rst = 1'b0;

        // LB / LBU at byte 3
        ex_to_mem_bus = mk(3'd1, 32'h100, 1, 0, 1, 1, 5'd3, 32'h1003); tick();
        ex_to_mem_bus = '0; data_sram_rdata = 32'h80FF_1234; #1;
        chk("lb", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'hFFFF_FF80}); check_all("lb");
        ex_to_mem_bus = mk(3'd2, 32'h104, 1, 0, 1, 1, 5'd3, 32'h1003); tick();
        ex_to_mem_bus = '0; #1;
        chk("lbu", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h0000_0080}); check_all("lbu");

        // LH at half 1, LHU at half 0
        ex_to_mem_bus = mk(3'd3, 32'h108, 1, 0, 1, 1, 5'd4, 32'h2002); tick();
        ex_to_mem_bus = '0; data_sram_rdata = 32'h8001_7FFF; #1;
        chk("lh", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'hFFFF_8001}); check_all("lh");
        ex_to_mem_bus = mk(3'd4, 32'h10C, 1, 0, 1, 1, 5'd4, 32'h2000); tick();
        ex_to_mem_bus = '0; #1;
        chk("lhu", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h0000_7FFF}); check_all("lhu");

        // Plain ALU result
        ex_to_mem_bus = mk(3'd0, 32'h110, 0, 0, 0, 1, 5'd5, 32'h1234_5678); tick();
        ex_to_mem_bus = '0; #1;
        chk("alu.wb", mem_to_wb_bus, {32'h110, 1'b1, 5'd5, 32'h1234_5678});
        chk("alu.rf", {32'd0, mem_to_rf_bus}, {32'd0, 1'b1, 5'd5, 32'h1234_5678});

        // LW frozen in MEM for 3 cycles while SRAM data changes
        ex_to_mem_bus = mk(3'd0, 32'h114, 1, 0, 1, 1, 5'd6, 32'h3000); tick();
        data_sram_rdata = 32'hDEAD_BEEF; stall = S_HOLD; #1;
        chk("lw.c0", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'hDEAD_BEEF});
        for (int i = 0; i < 3; i++) begin
            tick(); data_sram_rdata = 32'h0; #1;
            chk("lw.hold", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'hDEAD_BEEF});
            check_all("lw.hold");
        end
        stall = S_RUN; ex_to_mem_bus = mk(3'd0, 32'h118, 1, 0, 1, 1, 5'd7, 32'h3004); tick();
        data_sram_rdata = 32'hCAFE_F00D; #1;
        chk("lw.next", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'hCAFE_F00D}); check_all("lw.next");

        // Bubble insert, then the held EX value enters
        ex_to_mem_bus = mk(3'd0, 32'h11C, 0, 0, 0, 1, 5'd8, 32'hAAAA_0001); tick();
        stall = S_BUBBLE; ex_to_mem_bus = mk(3'd0, 32'h120, 0, 0, 0, 1, 5'd9, 32'hBBBB_0002); tick(); #1;
        chk("bubble.we_pc", {37'd0, mem_to_wb_bus[69:37]}, 70'd0); check_all("bubble");
        stall = S_RUN; tick(); #1;
        chk("bubble.after", mem_to_wb_bus, {32'h120, 1'b1, 5'd9, 32'hBBBB_0002});

        // Reset while a load is frozen
        ex_to_mem_bus = mk(3'd1, 32'h124, 1, 0, 1, 1, 5'd10, 32'h4001); tick();
        stall = S_HOLD; data_sram_rdata = 32'h1234_8000; tick(); tick();
        rst = 1'b1; tick(); #1;
        chk("rst_stall.wb", mem_to_wb_bus, 70'd0);
        chk("rst_stall.bufv", {69'd0, dut.buf_valid}, 70'd0);
        rst = 1'b0; stall = S_RUN;

        // Randomized traffic against the reference
        for (int n = 0; n < 400; n++) begin
            int unsigned k;
            int unsigned s;
            k = $urandom_range(0, 2);
            case (k)
                0: ex_to_mem_bus = mk(3'($urandom_range(0, 7)), $urandom, 1, 0, 1, 1,
                                      5'($urandom), $urandom);
                1: ex_to_mem_bus = mk(3'd0, $urandom, 1, 4'($urandom_range(1, 15)), 0, 0,
                                      5'($urandom), $urandom);
                default: ex_to_mem_bus = mk(3'd0, $urandom, 0, 0, 0, 1'($urandom),
                                            5'($urandom), $urandom);
            endcase
            s = $urandom_range(0, 9);
            stall = (s < 5) ? S_RUN : (s < 8) ? S_HOLD : S_BUBBLE;
            rst = ($urandom_range(0, 49) == 0);
            data_sram_rdata = $urandom;
            #1;
            check_all("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
